// File: rtl/fc_layer_ctrl.sv
// fc_layer_ctrl: sequencer for one fully connected layer.
// Drives the shared weight ROM address and node strobes in lockstep.
module fc_layer_ctrl #(
    parameter int INPUT_HEIGHT = 4,
    parameter int NUM_NODES    = 4,
    localparam int KW = $clog2(INPUT_HEIGHT + 1),
    localparam int SW = (INPUT_HEIGHT > 1) ? $clog2(INPUT_HEIGHT) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 in_load_o,
    output logic                 clr_sum_o,
    output logic [KW-1:0]        mem_addr_o,
    output logic                 en_sum_o,
    output logic [SW-1:0]        sel_o,
    output logic                 add_bias_o,
    output logic                 out_load_o,
    input  logic [NUM_NODES-1:0] ovf_i,
    output logic                 ovf_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_BIAS,
        S_OUT,
        S_HOLD
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [KW-1:0] r_k;
    logic          r_ovf;
    logic          w_accept;
    logic          w_last;

    assign w_accept = (r_state == S_IDLE) && valid_i;
    assign w_last   = (r_k == KW'(INPUT_HEIGHT - 1));
    assign ovf_o    = r_ovf;

    // State, term counter and sticky overflow registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_k   <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (en_sum_o && (|ovf_i)) begin
                    r_ovf <= 1'b1;
                end
                if ((r_state == S_MAC) && !w_last) begin
                    r_k <= r_k + KW'(1);
                end
            end
        end
    end

    // Next-state decode and per-state strobes
    always_comb begin
        w_next     = r_state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        in_load_o  = 1'b0;
        clr_sum_o  = 1'b0;
        mem_addr_o = '0;
        en_sum_o   = 1'b0;
        sel_o      = '0;
        add_bias_o = 1'b0;
        out_load_o = 1'b0;
        busy_o     = 1'b1;
        unique case (r_state)
            S_IDLE: begin
                ready_o = 1'b1;
                busy_o  = 1'b0;
                if (valid_i) begin
                    in_load_o = 1'b1;
                    clr_sum_o = 1'b1;
                    w_next    = S_MAC;
                end
            end
            S_MAC: begin
                en_sum_o   = 1'b1;
                sel_o      = r_k[SW-1:0];
                mem_addr_o = r_k + KW'(1);
                if (w_last) begin
                    w_next = S_BIAS;
                end
            end
            S_BIAS: begin
                en_sum_o   = 1'b1;
                add_bias_o = 1'b1;
                mem_addr_o = KW'(INPUT_HEIGHT);
                w_next     = S_OUT;
            end
            S_OUT: begin
                out_load_o = 1'b1;
                w_next     = S_HOLD;
            end
            S_HOLD: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// tb_fc_layer_ctrl: drives INPUT_HEIGHT=4 and =1 controllers in parallel
// and compares both against a cycle-timeline reference model.
module tb_fc_layer_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       vin;
    logic       rin;
    logic [3:0] ovf;

    logic       a_rdy, a_vld, a_inl, a_clr, a_en, a_bias, a_outl, a_ov, a_bsy;
    logic [2:0] a_mem;
    logic [1:0] a_sel;
    logic       b_rdy, b_vld, b_inl, b_clr, b_en, b_bias, b_outl, b_ov, b_bsy;
    logic [0:0] b_mem;
    logic [0:0] b_sel;

    int errors = 0;
    int checks = 0;

    int ph [2] = '{0, 0};
    bit mo [2] = '{1'b0, 1'b0};
    int ih [2] = '{4, 1};

    always #5 clk = ~clk;

    fc_layer_ctrl #(.INPUT_HEIGHT(4), .NUM_NODES(4)) u_a (
        .clk_i(clk), .reset_i(rst), .valid_i(vin), .ready_o(a_rdy),
        .valid_o(a_vld), .ready_i(rin), .in_load_o(a_inl),
        .clr_sum_o(a_clr), .mem_addr_o(a_mem), .en_sum_o(a_en),
        .sel_o(a_sel), .add_bias_o(a_bias), .out_load_o(a_outl),
        .ovf_i(ovf), .ovf_o(a_ov), .busy_o(a_bsy)
    );

    fc_layer_ctrl #(.INPUT_HEIGHT(1), .NUM_NODES(4)) u_b (
        .clk_i(clk), .reset_i(rst), .valid_i(vin), .ready_o(b_rdy),
        .valid_o(b_vld), .ready_i(rin), .in_load_o(b_inl),
        .clr_sum_o(b_clr), .mem_addr_o(b_mem), .en_sum_o(b_en),
        .sel_o(b_sel), .add_bias_o(b_bias), .out_load_o(b_outl),
        .ovf_i(ovf), .ovf_o(b_ov), .busy_o(b_bsy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Expected outputs derived from cycles elapsed since the accept edge:
    // 1..H weighted terms, H+1 bias, H+2 output load, H+3.. holding.
    task automatic check_dut(input int d, input logic rdy, vld, inl, clr,
                             input logic [31:0] mem, input logic en,
                             input logic [31:0] sel, input logic bias,
                             input logic outl, ov, bsy);
        int p;
        int h;
        bit mac;
        string n;
        p   = ph[d];
        h   = ih[d];
        mac = (p >= 1) && (p <= h);
        n   = $sformatf("h%0d", h);
        chk({n, ".ready"}, 32'(rdy), 32'(p == 0));
        chk({n, ".valid"}, 32'(vld), 32'(p >= h + 3));
        chk({n, ".in_load"}, 32'(inl), 32'((p == 0) && vin));
        chk({n, ".clr_sum"}, 32'(clr), 32'((p == 0) && vin));
        chk({n, ".mem_addr"}, mem,
            mac ? 32'(p) : (p == h + 1) ? 32'(h) : 32'd0);
        chk({n, ".en_sum"}, 32'(en), 32'(mac || (p == h + 1)));
        chk({n, ".sel"}, sel, mac ? 32'(p - 1) : 32'd0);
        chk({n, ".add_bias"}, 32'(bias), 32'(p == h + 1));
        chk({n, ".out_load"}, 32'(outl), 32'(p == h + 2));
        chk({n, ".ovf"}, 32'(ov), 32'(mo[d]));
        chk({n, ".busy"}, 32'(bsy), 32'(p != 0));
    endtask

    task automatic upd(input int d);
        int h;
        h = ih[d];
        if (rst) begin
            ph[d] = 0;
            mo[d] = 1'b0;
        end else if (ph[d] == 0) begin
            if (vin) begin
                ph[d] = 1;
                mo[d] = 1'b0;
            end
        end else if (ph[d] >= h + 3) begin
            if (rin) ph[d] = 0;
        end else begin
            if ((ph[d] <= h + 1) && (|ovf)) mo[d] = 1'b1;
            ph[d] = ph[d] + 1;
        end
    endtask

    task automatic cyc(input logic v, input logic r, input logic [3:0] o,
                       input logic rs);
        vin = v;
        rin = r;
        ovf = o;
        rst = rs;
        @(negedge clk);
        check_dut(0, a_rdy, a_vld, a_inl, a_clr, 32'(a_mem), a_en,
                  32'(a_sel), a_bias, a_outl, a_ov, a_bsy);
        check_dut(1, b_rdy, b_vld, b_inl, b_clr, 32'(b_mem), b_en,
                  32'(b_sel), b_bias, b_outl, b_ov, b_bsy);
        @(posedge clk);
        upd(0);
        upd(1);
        #1;
    endtask

    initial begin
        vin = 1'b0;
        rin = 1'b0;
        ovf = 4'h0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        repeat (3) cyc(1'b0, 1'b0, 4'h0, 1'b0);

        // single vector with 5 cycles of backpressure in HOLD
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        repeat (11) cyc(1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 4'h0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 4'h0, 1'b0);

        // back-to-back vectors, no backpressure
        repeat (40) cyc(1'b1, 1'b1, 4'h0, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, 4'h0, 1'b0);

        // overflow on T3, then pulses while idle, then next accept clears
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 4'b0010, 1'b0);
        repeat (6) cyc(1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b1, 4'h0, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 4'hf, 1'b0);
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        repeat (10) cyc(1'b0, 1'b1, 4'h0, 1'b0);

        // reset at T3 aborts the vector
        cyc(1'b1, 1'b0, 4'h0, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 4'h0, 1'b0);
        cyc(1'b0, 1'b0, 4'h0, 1'b1);
        repeat (10) cyc(1'b0, 1'b1, 4'h0, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'($urandom_range(0, 99) < 40),
                1'($urandom_range(0, 99) < 50),
                ($urandom_range(0, 99) < 15) ? 4'($urandom) : 4'h0,
                1'($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
